lifo_buffer: RTL and testbench
==============================

LIFO_BUFFER -- requirements
Module: lifo_buffer

Interface
REQ-001 SHALL have parameter p_width, default 32, data word width in bits.
REQ-002 SHALL have parameter p_depth, default 32, number of entries (>=2).
REQ-003 SHALL have parameter p_af_thresh, default 4, almost_full margin in entries.
REQ-004 SHALL have parameter p_ae_thresh, default 4, almost_empty level in entries.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clock  input  1  rising-edge clock.
REQ-007 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port clear  input  1  synchronous flush; discards all entries.
REQ-009 SHALL have port wr_req  input  1  push request.
REQ-010 SHALL have port wr_data  input  p_width  push data.
REQ-011 SHALL have port full  output  1  count == p_depth.
REQ-012 SHALL have port almost_full  output  1  count >= p_depth - p_af_thresh.
REQ-013 SHALL have port rd_req  input  1  pop request.
REQ-014 SHALL have port rd_data  output  p_width  current top of stack (show-ahead).
REQ-015 SHALL have port empty  output  1  count == 0.
REQ-016 SHALL have port almost_empty  output  1  count <= p_ae_thresh.
REQ-017 SHALL have port count  output  $clog2(p_depth+1)  current occupancy.
REQ-018 SHALL have ports overflow and underflow  output  1 each  sticky error flags (present only under REQ-034).

Function
REQ-019 rd_data SHALL equal the top-of-stack entry whenever count>0, and 0 when empty; a pop consumes the value shown that cycle (zero read latency).
REQ-020 Push only (wr_req & !rd_req & !full): store wr_data at index count, count+1; rd_data = wr_data next cycle.
REQ-021 Pop only (rd_req & !wr_req & !empty): count-1; rd_data shows previous entry next cycle.
REQ-022 Push+pop, count>0 (including full): replace top with wr_data, count unchanged; popped value = old top.
REQ-023 Push+pop when empty: push executes, pop ignored, underflow event.
REQ-024 Push when full without pop: wr_data dropped, state unchanged, overflow event.
REQ-025 Pop when empty without push: ignored, state unchanged, underflow event.
REQ-026 clear SHALL set count=0 next cycle, ignoring same-cycle wr_req/rd_req; storage contents need not be zeroed.
REQ-027 All flags SHALL be decoded from registered count only (no input-to-flag combinational path).
REQ-028 count SHALL never exceed p_depth nor wrap below 0.

Reset
REQ-029 reset_n low at a rising edge SHALL force count=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless p_depth-p_af_thresh<=0), rd_data=0, overflow=0, underflow=0.
REQ-030 Reset SHALL take priority over clear, wr_req and rd_req; reset mid-operation discards all entries.
REQ-031 Storage array SHALL NOT require reset.

Configuration
REQ-032 Macro LIFO_BUFFER_ERR_EN selects error reporting.
REQ-033 Without it: overflow/underflow ports absent; illegal requests silently ignored per REQ-023..025.
REQ-034 With it: overflow/underflow present, set on the respective event, held until reset_n or clear.

Structure
REQ-035 Package lifo_buffer_pkg SHALL hold count-width helper function and the op-decode enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE}.
REQ-036 Storage SHALL be sub-module lifo_buffer_ram: one write port, one async read port addressed at count-1.

Verification (p_depth=8, p_af_thresh=2, p_ae_thresh=2, p_width=32)
REQ-037 Push 0..7 -> full=1 at count 8, almost_full from count 6; pops return 7,6,...,0; empty=1 after eighth pop.
REQ-038 Full, push 0xAA + pop same cycle -> popped 7, count stays 8, next top 0xAA.
REQ-039 Full, push 0x55 alone -> count 8, top unchanged; overflow=1 with macro, no port without.
REQ-040 Empty, pop alone -> count 0, underflow=1; then push+pop 0x11 -> count 1, top 0x11.
REQ-041 count 5, assert clear with wr_req -> count 0, empty=1, errors cleared next cycle.
REQ-042 Push 3 entries, drive reset_n low one cycle -> all outputs at REQ-029 values next edge.

Source files
------------

// File: rtl/lifo_buffer_pkg.sv
// Shared types and helpers for the LIFO buffer: operation decode enum and count width.
// Optional error flags are enabled with the LIFO_BUFFER_ERR_EN macro.
package lifo_buffer_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // Occupancy runs 0..depth inclusive, so one extra code point is needed.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_buffer_if.sv
// Request/status bundle for lifo_buffer; master drives requests, slave reports state.
// overflow/underflow exist only when LIFO_BUFFER_ERR_EN is defined.
interface lifo_buffer_if #(
  parameter int p_width = 32,
  parameter int p_depth = 32
);
  import lifo_buffer_pkg::*;

  localparam int p_cw = count_width(p_depth);

  logic               clear;
  logic               wr_req;
  logic [p_width-1:0] wr_data;
  logic               rd_req;
  logic [p_width-1:0] rd_data;
  logic               full;
  logic               almost_full;
  logic               empty;
  logic               almost_empty;
  logic [p_cw-1:0]    count;
`ifdef LIFO_BUFFER_ERR_EN
  logic               overflow;
  logic               underflow;

  modport master (
    output clear, wr_req, wr_data, rd_req,
    input  rd_data, full, almost_full, empty, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  clear, wr_req, wr_data, rd_req,
    output rd_data, full, almost_full, empty, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output clear, wr_req, wr_data, rd_req,
    input  rd_data, full, almost_full, empty, almost_empty, count
  );
  modport slave (
    input  clear, wr_req, wr_data, rd_req,
    output rd_data, full, almost_full, empty, almost_empty, count
  );
`endif

endinterface

// File: rtl/lifo_buffer_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; occupancy tracking lives in the parent.
module lifo_buffer_ram #(
  parameter int p_width = 32,
  parameter int p_depth = 32,
  parameter int p_aw    = $clog2(p_depth)
) (
  input  logic               clock,
  input  logic               i_we,
  input  logic [p_aw-1:0]    i_waddr,
  input  logic [p_width-1:0] i_wdata,
  input  logic [p_aw-1:0]    i_raddr,
  output logic [p_width-1:0] o_rdata
);

  logic [p_width-1:0] r_mem [p_depth];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_buffer.sv
// Show-ahead LIFO stack with occupancy flags; pop reads the top with zero latency.
// Define LIFO_BUFFER_ERR_EN to add sticky overflow/underflow flags.
module lifo_buffer
  import lifo_buffer_pkg::*;
#(
  parameter int p_width     = 32,
  parameter int p_depth     = 32,
  parameter int p_af_thresh = 4,
  parameter int p_ae_thresh = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  lifo_buffer_if.slave bus
);

  localparam int p_cw       = count_width(p_depth);
  localparam int p_aw       = $clog2(p_depth);
  localparam int c_af_level = p_depth - p_af_thresh;

  localparam logic [p_cw-1:0] c_one   = p_cw'(1);
  localparam logic [p_cw-1:0] c_depth = p_cw'(p_depth);

  logic [p_cw-1:0]    r_count;
  op_e                w_op;
  logic               w_full;
  logic               w_empty;
  logic               w_af;
  logic               w_ae;
  logic               w_we;
  logic [p_aw-1:0]    w_top_idx;
  logic [p_aw-1:0]    w_waddr;
  logic [p_aw-1:0]    w_raddr;
  logic [p_width-1:0] w_ram_rdata;

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_top_idx = p_aw'(r_count - c_one);

  // Thresholds outside the count range degenerate to constant flags.
  generate
    if (c_af_level <= 0) begin : g_af_const
      assign w_af = 1'b1;
    end else begin : g_af_cmp
      assign w_af = (r_count >= p_cw'(c_af_level));
    end
    if (p_ae_thresh >= p_depth) begin : g_ae_const
      assign w_ae = 1'b1;
    end else begin : g_ae_cmp
      assign w_ae = (r_count <= p_cw'(p_ae_thresh));
    end
  endgenerate

  // Push+pop on an empty stack degrades to a plain push.
  always_comb begin
    w_op = OP_IDLE;
    if (bus.wr_req && bus.rd_req) begin
      w_op = w_empty ? OP_PUSH : OP_REPLACE;
    end else if (bus.wr_req) begin
      if (!w_full) w_op = OP_PUSH;
    end else if (bus.rd_req) begin
      if (!w_empty) w_op = OP_POP;
    end
  end

  assign w_we    = reset_n && !bus.clear && ((w_op == OP_PUSH) || (w_op == OP_REPLACE));
  assign w_waddr = (w_op == OP_PUSH) ? p_aw'(r_count) : w_top_idx;
  assign w_raddr = w_empty ? '0 : w_top_idx;

  lifo_buffer_ram #(
    .p_width (p_width),
    .p_depth (p_depth),
    .p_aw    (p_aw)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (bus.clear) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_count <= r_count + c_one;
        OP_POP:  r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LIFO_BUFFER_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_ovf_evt = bus.wr_req && !bus.rd_req && w_full;
  assign w_unf_evt = bus.rd_req && w_empty;

  always_ff @(posedge clock) begin
    if (!reset_n || bus.clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) r_overflow  <= 1'b1;
      if (w_unf_evt) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = w_af;
  assign bus.almost_empty = w_ae;
  assign bus.rd_data      = w_empty ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_lifo_buffer.sv
// Bench for lifo_buffer: directed vector table, reset sequence, then random traffic vs a queue model.
module tb_lifo_buffer;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lifo_buffer_if #(.p_width(W), .p_depth(D)) bus ();

  lifo_buffer #(
    .p_width     (W),
    .p_depth     (D),
    .p_af_thresh (AF),
    .p_ae_thresh (AE)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          clr, wr, rd;
    logic [31:0] d;
    int          cnt;
    logic [31:0] top;
    bit          full, af, empty, ae, ovf, unf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] m_q[$];
  bit          m_ovf, m_unf;

  function automatic vec_t mk(bit c, bit w, bit r, logic [31:0] d, int cnt, logic [31:0] top,
                              bit full, bit af, bit empty, bit ae, bit ovf, bit unf);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.d = d; v.cnt = cnt; v.top = top;
    v.full = full; v.af = af; v.empty = empty; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of requests; outputs are sampled on the following falling edge.
  task automatic drive(input bit c, input bit w, input bit r, input logic [31:0] d);
    bus.clear   = c;
    bus.wr_req  = w;
    bus.rd_req  = r;
    bus.wr_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(input bit c, input bit w, input bit r, input logic [31:0] d);
    if (c) begin
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (w && r) begin
      if (m_q.size() > 0) m_q[m_q.size()-1] = d;
      else begin
        m_q.push_back(d);
        m_unf = 1;
      end
    end else if (w) begin
      if (m_q.size() == D) m_ovf = 1;
      else m_q.push_back(d);
    end else if (r) begin
      if (m_q.size() == 0) m_unf = 1;
      else void'(m_q.pop_back());
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".rd_data"}, bus.rd_data, (n > 0) ? m_q[n-1] : 32'h0);
    chk({tag, ".full"}, 32'(bus.full), 32'(n == D));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= D - AF));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
`ifdef LIFO_BUFFER_ERR_EN
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    bus.clear = 0; bus.wr_req = 0; bus.rd_req = 0; bus.wr_data = '0;

    // Directed table, values worked out by hand for depth 8, thresholds 2.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, 32'(i), i + 1, 32'(i), (i + 1) == 8, (i + 1) >= 6, 0, (i + 1) <= 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'hAA, 8, 32'hAA, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h55, 8, 32'hAA, 1, 1, 0, 0, 1, 0));
    for (int i = 7; i >= 0; i--)
      vecs.push_back(mk(0, 0, 1, 0, i, (i == 0) ? 32'h0 : 32'(i - 1), 0, i >= 6, i == 0, i <= 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h11, 1, 32'h11, 0, 0, 0, 1, 1, 1));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 1, 0, 32'h20 + 32'(i), i + 1, 32'h20 + 32'(i), 0, 0, 0, (i + 1) <= 2, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h99, 0, 32'h0, 0, 0, 1, 1, 0, 0));

    // Reset state
    rst_n = 0;
    drive(0, 0, 0, 0);
    check_model("reset");
    rst_n = 1;

    foreach (vecs[i]) begin
      string t;
      drive(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].d);
      t = $sformatf("vec%0d", i);
      chk({t, ".count"}, 32'(bus.count), 32'(vecs[i].cnt));
      chk({t, ".rd_data"}, bus.rd_data, vecs[i].top);
      chk({t, ".full"}, 32'(bus.full), 32'(vecs[i].full));
      chk({t, ".almost_full"}, 32'(bus.almost_full), 32'(vecs[i].af));
      chk({t, ".empty"}, 32'(bus.empty), 32'(vecs[i].empty));
      chk({t, ".almost_empty"}, 32'(bus.almost_empty), 32'(vecs[i].ae));
`ifdef LIFO_BUFFER_ERR_EN
      chk({t, ".overflow"}, 32'(bus.overflow), 32'(vecs[i].ovf));
      chk({t, ".underflow"}, 32'(bus.underflow), 32'(vecs[i].unf));
`endif
      $display("vec %0d clr=%0d wr=%0d rd=%0d d=%0h -> count=%0d rd_data=%0h",
               i, vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].d, bus.count, bus.rd_data);
    end

    // Reset mid-operation wins over clear and push in the same cycle.
    m_q.delete(); m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'hC0 + 32'(i));
      model_step(0, 1, 0, 32'hC0 + 32'(i));
      check_model($sformatf("pre_rst%0d", i));
    end
    drive(0, 0, 1, 0);
    model_step(0, 0, 1, 0);
    check_model("pre_rst_pop");
    drive(0, 1, 0, 32'hC7);
    model_step(0, 1, 0, 32'hC7);
    rst_n = 0;
    drive(1, 1, 0, 32'hDEAD);
    m_q.delete(); m_ovf = 0; m_unf = 0;
    check_model("mid_reset");
    rst_n = 1;
    drive(0, 1, 0, 32'hBEEF);
    model_step(0, 1, 0, 32'hBEEF);
    check_model("post_reset_push");
    $display("reset sequence: count=%0d rd_data=%0h", bus.count, bus.rd_data);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int n = 0; n < 800; n++) begin
      int bias;
      bit c, w, r;
      logic [31:0] d;
      bias = ((n / 100) % 2 == 0) ? 70 : 30;
      w = ($urandom % 100) < bias;
      r = ($urandom % 100) < (100 - bias);
      c = ($urandom % 50) == 0;
      d = $urandom;
      drive(c, w, r, d);
      model_step(c, w, r, d);
      check_model($sformatf("rnd%0d", n));
      $display("rnd %0d clr=%0d wr=%0d rd=%0d d=%0h -> count=%0d rd_data=%0h",
               n, c, w, r, d, bus.count, bus.rd_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
